count_sched: RTL and testbench
==============================

# count_sched

Sequencer and round-robin arbiter for the shared dual 64-bit counter (`Clk`/`Reset`/`Slt`/`En` → `Output0`/`Output1`). Two requesters each ask for a burst of N increments on a chosen counter. The counter has a single `En`/`Slt` pair, so only one burst can run at a time. This block grants bursts in turn, drives `En`/`Slt` for exactly N cycles, and reports acceptance and completion per requester.

## Interface
- `LEN_W`, default 8: width of the burst-length inputs. Maximum burst is 2^LEN_W−1.
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Req` in 2: level request per requester. Held until its `Ack`.
- `Len0`, `Len1` in LEN_W: burst length for requester 0/1. Sampled when the grant is taken.
- `Sel` in 2: `Sel[i]` is the target counter for requester i (0→`Output0`, 1→`Output1`). Sampled with `Len`.
- `Ack` out 2: one-cycle pulse, request i accepted.
- `Done` out 2: one-cycle pulse, burst i finished.
- `Busy` out 1: high whenever state ≠ IDLE.
- `Owner` out 1: index of the current or last granted requester.
- `En` out 1: counter enable, to the counter's `En`.
- `Slt` out 1: counter select, to the counter's `Slt`.

## Operation
- All outputs are registered. Reset values: `Ack`=0, `Done`=0, `Busy`=0, `Owner`=0, `En`=0, `Slt`=0. The round-robin pointer resets to "last served = 1", so requester 0 wins first.
- States are IDLE, RUN and DONE.
- **IDLE**
  - If any `Req` bit is high, pick a winner w. A single requester wins outright. If both are high, the one not served last wins.
  - Latch `Len_w` into `rem` and `Sel[w]` into `Slt`; set `Owner`=w.
  - Next state: RUN if `Len_w`≠0, else DONE.
- **Entering RUN or DONE from IDLE:** `Ack[w]`=1 for that first cycle only.
- **RUN**
  - `En`=1 and `Slt`=latched select. `rem` decrements every cycle.
  - When `rem`==1, next state is DONE.
  - `En` is high for exactly `Len_w` consecutive cycles.
- **DONE**
  - `En`=0 and `Done[w]`=1 for one cycle.
  - Update the pointer to "last served = w". Next state is IDLE.
- A `Req` that is still high in IDLE after its `Done` is a new request.
- `Req` and `Len` changes during RUN/DONE are ignored.
- Dropping `Req` before `Ack` withdraws the request; no `Ack` or `Done` follows.
- `rem` is LEN_W bits wide and never wraps: length 0 skips RUN entirely.
- `Slt` holds its last value when `En`=0.

## Timing
- Request latency: `Req` high at edge k in IDLE gives `Ack` and (if Len>0) first `En` in cycle k+1.
- `Done` arrives in cycle k+1+Len. For Len=0, `Ack` and `Done` fall in the same cycle k+1.
- The minimum turnaround is one IDLE cycle between DONE and the next `Ack`, so the burst period is Len+2 cycles.
- Simultaneous requests are serialised. The loser keeps `Req` high and is granted on the next IDLE.
- `Reset_n` asserted mid-burst:
  - All outputs drop to their reset values immediately, without waiting for `Clk`.
  - The burst is abandoned with no `Done`.
  - The counter has its own reset and is not cleared by this block.

## Structure
- Shared package holds the state encoding constants (`S_IDLE`, `S_RUN`, `S_DONE`) and the default `LEN_W`.
- One natural sub-module, `rr_arb2`: 2-way round-robin pick from `Req` and the last-served pointer, returning the winner index and a valid flag.
- The remaining FSM and `rem` counter stay in `count_sched`.

## Test plan
- **Reset:** hold `Reset_n`=0 for 3 cycles → `En`,`Slt`,`Ack`,`Done`,`Busy`,`Owner` all 0.
- **Single burst:** `Req`=01, `Len0`=5, `Sel[0]`=1 →
  - `Ack[0]` next cycle.
  - `En`=1 with `Slt`=1 for exactly 5 cycles.
  - Counter `Output1` increases by 5 and `Output0` is unchanged.
  - `Done[0]` in the following cycle.
- **Contention:** after reset, `Req`=11, `Len0`=3, `Len1`=2 →
  - Requester 0 gets 3 `En` cycles, then one IDLE cycle.
  - Requester 1 gets 2 `En` cycles.
  - Reasserting `Req`=11 then grants requester 0 first.
- **Zero length:** `Req`=10, `Len1`=0 → `Ack[1]` and `Done[1]` in the same cycle, `En` never high.
- **Reset mid-burst:** `Len0`=6, pull `Reset_n` low after 2 `En` cycles →
  - `En` falls asynchronously.
  - No `Done`.
  - Counter output has advanced by 2.
  - `Busy`=0 after release.
- **Max length:** `Len0`=255 → exactly 255 `En` cycles, no wrap, then `Done[0]`.

Source files
------------

// File: rtl/count_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_sched_pkg
// Description : Shared definitions for the dual-counter burst sequencer.
//               - LEN_W_DEFAULT : default width of the burst-length inputs
//               - state_t       : sequencer states (S_IDLE, S_RUN, S_DONE)
//               - onehot2       : requester index to 2-bit one-hot pulse
// Revision    : 1.0 - initial release
// ============================================================================
package count_sched_pkg;

  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Per-requester strobes (ack/done) are one-hot in the requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : count_sched_if
// Description : Requester/status bundle of the burst sequencer.
//               master : requester side (drives req, len0, len1, sel)
//               slave  : sequencer side (drives ack, done, busy, owner,
//                        en, slt)
//               req[1:0]   level request per requester
//               len0/len1  burst length per requester
//               sel[1:0]   target counter per requester
//               ack[1:0]   one-cycle accept pulse
//               done[1:0]  one-cycle completion pulse
//               busy       sequencer not idle
//               owner      current / last granted requester
//               en, slt    counter enable and counter select
// Revision    : 1.0 - initial release
// ============================================================================
interface count_sched_if
  import count_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
);

  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       sel;
  logic [1:0]       ack;
  logic [1:0]       done;
  logic             busy;
  logic             owner;
  logic             en;
  logic             slt;

  modport master (
    output req, len0, len1, sel,
    input  ack, done, busy, owner, en, slt
  );

  modport slave (
    input  req, len0, len1, sel,
    output ack, done, busy, owner, en, slt
  );

endinterface
`default_nettype wire

// File: rtl/count_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick (purely combinational).
//               req[1:0] : pending requests
//               last     : index of the requester served last
//               win      : winning requester index
//               valid    : at least one request pending
//               A lone requester always wins; on a tie the requester that
//               was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import count_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (&req) begin
      win = ~last;
    end else begin
      // With at most one bit set, bit 1 alone decides the index.
      win = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module      : count_sched
// Description : Burst sequencer and round-robin arbiter for the shared dual
//               64-bit counter. Grants one burst at a time, drives en/slt for
//               exactly len cycles and reports accept/finish per requester.
//               clk   : rising-edge clock
//               rst_n : asynchronous active-low reset
//               bus   : count_sched_if.slave (requests in, status/counter out)
// Revision    : 1.0 - initial release
// ============================================================================
module count_sched
  import count_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
)(
  input  logic         clk,
  input  logic         rst_n,
  count_sched_if.slave bus
);

  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic             r_last;
  logic [1:0]       r_ack;
  logic [1:0]       r_done;
  logic             r_busy;
  logic             r_owner;
  logic             r_en;
  logic             r_slt;

  logic             w_win;
  logic             w_valid;
  logic [LEN_W-1:0] w_len;
  logic             w_sel;

  rr_arb2 u_arb (
    .req   (bus.req),
    .last  (r_last),
    .win   (w_win),
    .valid (w_valid)
  );

  assign w_len = w_win ? bus.len1 : bus.len0;
  assign w_sel = bus.sel[w_win];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_last  <= 1'b1;   // requester 0 wins the first tie
      r_ack   <= 2'b00;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_en    <= 1'b0;
      r_slt   <= 1'b0;
    end else begin
      r_ack  <= 2'b00;
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_owner <= w_win;
            r_slt   <= w_sel;
            r_rem   <= w_len;
            r_busy  <= 1'b1;
            r_ack   <= onehot2(w_win);
            if (w_len != '0) begin
              r_en    <= 1'b1;
              r_state <= S_RUN;
            end else begin
              // Zero-length burst: accept and finish in the same cycle.
              r_done  <= onehot2(w_win);
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_rem <= r_rem - LEN_W'(1);
          // rem counts the en cycles still to go, this one included.
          if (r_rem == LEN_W'(1)) begin
            r_en    <= 1'b0;
            r_done  <= onehot2(r_owner);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack   = r_ack;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.owner = r_owner;
  assign bus.en    = r_en;
  assign bus.slt   = r_slt;

endmodule
`default_nettype wire

// File: tb/tb_count_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sched
// Description : Self-checking bench for count_sched. A timestamp-based model
//               of the grant schedule predicts all outputs each cycle;
//               directed scenarios pin absolute timings and counter deltas.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  count_sched_if #(.LEN_W(8)) bus ();

  count_sched #(.LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Stand-in for the shared counter: its own state, never cleared by rst_n.
  longint unsigned cnt0 = 0;
  longint unsigned cnt1 = 0;
  always @(posedge clk) begin
    if (rst_n && bus.en) begin
      if (bus.slt) cnt1 <= cnt1 + 1;
      else         cnt0 <= cnt0 + 1;
    end
  end

  // Schedule model: a grant taken at edge g lasting L busies the intervals
  // after edges g..g+L (ack after g, en after g..g+L-1, done after g+L);
  // the next grant may be taken at edge g+L+2.
  int unsigned edge_n    = 0;
  int unsigned g_edge    = 0;
  int unsigned g_len     = 0;
  int unsigned free_edge = 0;
  bit          have      = 1'b0;
  bit          g_w       = 1'b0;
  bit          m_last    = 1'b1;
  bit          m_owner   = 1'b0;
  bit          m_slt     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_slt = 1'b0; free_edge = 0;
    end else begin
      edge_n++;
      if (edge_n >= free_edge && bus.req != 2'b00) begin
        if (bus.req == 2'b11) g_w = (m_last == 1'b0);
        else                  g_w = (bus.req == 2'b10);
        g_edge    = edge_n;
        g_len     = g_w ? int'(bus.len1) : int'(bus.len0);
        m_owner   = g_w;
        m_slt     = bus.sel[g_w];
        m_last    = g_w;
        have      = 1'b1;
        free_edge = edge_n + g_len + 2;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0]  e_ack;
    logic [1:0]  e_done;
    logic        e_busy;
    logic        e_en;
    int unsigned d;
    e_ack = 2'b00; e_done = 2'b00; e_busy = 1'b0; e_en = 1'b0;
    d = edge_n - g_edge;
    if (rst_n && have && d <= g_len) begin
      e_busy = 1'b1;
      e_en   = (d < g_len);
      if (d == 0)     e_ack  = g_w ? 2'b10 : 2'b01;
      if (d == g_len) e_done = g_w ? 2'b10 : 2'b01;
    end
    check("outputs{ack,done,busy,owner,en,slt}",
          {56'd0, bus.ack, bus.done, bus.busy, bus.owner, bus.en, bus.slt},
          {56'd0, e_ack, e_done, e_busy, m_owner, e_en, m_slt});
  end

  // Directed observation: first ack/done time per requester, en cycles per
  // target counter; a requester's req is dropped once it is accepted.
  int ack_t[2];
  int done_t[2];
  int en_cnt[2];

  task automatic observe(input int ncyc);
    for (int i = 0; i < 2; i++) begin
      ack_t[i] = -1; done_t[i] = -1; en_cnt[i] = 0;
    end
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (bus.ack[i] && ack_t[i] < 0) begin
          ack_t[i]    = t;
          bus.req[i]  = 1'b0;
        end
        if (bus.done[i] && done_t[i] < 0) done_t[i] = t;
      end
      if (bus.en) en_cnt[bus.slt]++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned c0;
    longint unsigned c1;
    bus.req = 2'b00; bus.len0 = '0; bus.len1 = '0; bus.sel = 2'b00;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {56'd0, bus.ack, bus.done, bus.busy, bus.owner, bus.en, bus.slt}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // Single burst: requester 0, len 5, counter 1.
    c0 = cnt0; c1 = cnt1;
    bus.req = 2'b01; bus.len0 = 8'd5; bus.sel = 2'b01;
    observe(8);
    check("single_ack_t",   ack_t[0],  1);
    check("single_done_t",  done_t[0], 6);
    check("single_en_slt1", en_cnt[1], 5);
    check("single_en_slt0", en_cnt[0], 0);
    check("single_cnt1",    cnt1 - c1, 5);
    check("single_cnt0",    cnt0 - c0, 0);

    // Contention after reset.
    do_reset();
    c0 = cnt0; c1 = cnt1;
    bus.req = 2'b11; bus.len0 = 8'd3; bus.len1 = 8'd2; bus.sel = 2'b10;
    observe(10);
    check("cont_ack0",  ack_t[0],  1);
    check("cont_done0", done_t[0], 4);
    check("cont_ack1",  ack_t[1],  6);
    check("cont_done1", done_t[1], 8);
    check("cont_en0",   en_cnt[0], 3);
    check("cont_en1",   en_cnt[1], 2);
    check("cont_cnt0",  cnt0 - c0, 3);
    check("cont_cnt1",  cnt1 - c1, 2);
    bus.req = 2'b11; bus.len0 = 8'd1; bus.len1 = 8'd1;
    observe(8);
    check("reassert_ack0", ack_t[0], 1);
    check("reassert_ack1", ack_t[1], 4);

    // Zero-length burst.
    bus.req = 2'b10; bus.len1 = 8'd0; bus.sel = 2'b00;
    observe(4);
    check("zero_ack1",  ack_t[1],  1);
    check("zero_done1", done_t[1], 1);
    check("zero_en",    en_cnt[0] + en_cnt[1], 0);

    // Reset in the middle of a burst, after two counted en cycles.
    c0 = cnt0;
    bus.req = 2'b01; bus.len0 = 8'd6; bus.sel = 2'b00;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("midrst_en_async", bus.en, 0);
    check("midrst_busy_async", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cnt0", cnt0 - c0, 2);
    check("midrst_busy_after", bus.busy, 0);
    observe(4);
    check("midrst_no_done", {done_t[0] < 0, done_t[1] < 0}, 2'b11);

    // Maximum length.
    c1 = cnt1;
    bus.req = 2'b01; bus.len0 = 8'd255; bus.sel = 2'b01;
    observe(260);
    check("max_en",     en_cnt[1], 255);
    check("max_done_t", done_t[0], 256);
    check("max_cnt1",   cnt1 - c1, 255);

    // Randomized traffic, checked every cycle against the model.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int i = 0; i < 2; i++) begin
        if (!bus.req[i])                     bus.req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
      end
      bus.len0 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      bus.len1 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      bus.sel  = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
